// File: rtl/tohost_monitor.sv
// Simulation tohost monitor: watches core stores to the tohost word and reports pass, fail or
// watchdog timeout, with a cycle counter and a one-cycle-latency read port for the tohost word.
module tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter int unsigned TIMEOUT     = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_rvalid,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_num,
    output logic        timeout,
    output logic [31:0] cycles
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StRun     = 3'd1;
    localparam logic [2:0] StPass    = 3'd2;
    localparam logic [2:0] StFail    = 3'd3;
    localparam logic [2:0] StTimeout = 3'd4;

    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [31:0] tohost_q, tohost_d;
    logic [31:0] cycles_q, cycles_d;
    logic [30:0] fail_num_q, fail_num_d;
    logic        hit;

    // Byte offset within the tohost word is irrelevant.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^bus_addr[1:0];

    assign hit = (bus_addr[31:2] == TOHOST_ADDR[31:2]);

    always_comb begin
        state_d    = state_q;
        tohost_d   = tohost_q;
        cycles_d   = cycles_q;
        fail_num_d = fail_num_q;
        case (state_q)
            StIdle: state_d = StRun;
            StRun: begin
                if (cycles_q != 32'hFFFF_FFFF) begin
                    cycles_d = cycles_q + 32'd1;
                end
                if (bus_we && hit) begin
                    tohost_d = bus_wdata;
                    if (bus_wdata[0]) begin
                        if (bus_wdata == 32'd1) begin
                            state_d = StPass;
                        end else begin
                            state_d    = StFail;
                            fail_num_d = bus_wdata[31:1];
                        end
                    end
                end
                // A terminal store on the watchdog's last edge wins over the timeout.
                if (state_d == StRun && cycles_q == TimeoutLast) begin
                    state_d = StTimeout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tohost_q   <= 32'd0;
            cycles_q   <= 32'd0;
            fail_num_q <= 31'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            bus_rvalid <= 1'b0;
            bus_rdata  <= 32'd0;
        end else begin
            state_q    <= state_d;
            tohost_q   <= tohost_d;
            cycles_q   <= cycles_d;
            fail_num_q <= fail_num_d;
            done       <= (state_d == StPass) || (state_d == StFail) || (state_d == StTimeout);
            pass       <= (state_d == StPass);
            timeout    <= (state_d == StTimeout);
            bus_rvalid <= bus_re;
            // Reads see the pre-store value because tohost_q is sampled before this edge.
            bus_rdata  <= (bus_re && hit) ? tohost_q : 32'd0;
        end
    end

    assign fail_num = fail_num_q;
    assign cycles   = cycles_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// Bench for tohost_monitor: directed scenarios plus randomized traffic, every cycle compared
// against a behavioural model of the monitor's rules.
module tb_tohost_monitor;

    localparam int unsigned TMO  = 20;
    localparam logic [31:0] THA  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_we, bus_re;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_rvalid, done, pass, timeout;
    logic [30:0] fail_num;
    logic [31:0] cycles;

    int checks   = 0;
    int failures = 0;

    // Model: outcome is 0 not started, 1 running, 2 passed, 3 failed, 4 timed out.
    int          m_outcome;
    logic [31:0] m_tohost, m_rdata;
    longint      m_cycles;
    logic [30:0] m_fail;
    logic        m_rvalid;

    tohost_monitor #(.TOHOST_ADDR(THA), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_rvalid(bus_rvalid),
        .done      (done),
        .pass      (pass),
        .fail_num  (fail_num),
        .timeout   (timeout),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_hit(input logic [31:0] a);
        return (a >> 2) == (THA >> 2);
    endfunction

    // Apply the monitor's rules to one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit h;
        h = is_hit(bus_addr);
        if (rst) begin
            m_outcome = 0; m_tohost = 0; m_cycles = 0; m_fail = 0; m_rvalid = 0; m_rdata = 0;
            return;
        end
        m_rvalid = bus_re;
        m_rdata  = (bus_re && h) ? m_tohost : 32'd0;
        if (m_outcome == 0) begin
            m_outcome = 1;
        end else if (m_outcome == 1) begin
            bit terminal;
            terminal = bus_we && h && bus_wdata[0];
            if (bus_we && h) m_tohost = bus_wdata;
            if (terminal && bus_wdata == 1) m_outcome = 2;
            else if (terminal) begin
                m_outcome = 3;
                m_fail    = bus_wdata[31:1];
            end else if (m_cycles == TMO - 1) m_outcome = 4;
            if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
        end
    endtask

    task automatic check_all();
        chk("done",     {31'd0, done},    {31'd0, m_outcome >= 2});
        chk("pass",     {31'd0, pass},    {31'd0, m_outcome == 2});
        chk("timeout",  {31'd0, timeout}, {31'd0, m_outcome == 4});
        chk("fail_num", {1'b0, fail_num}, {1'b0, m_fail});
        chk("cycles",   cycles,           m_cycles[31:0]);
        chk("rvalid",   {31'd0, bus_rvalid}, {31'd0, m_rvalid});
        chk("rdata",    bus_rdata,        m_rdata);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic r, input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] d);
        rst = r; bus_we = we; bus_re = re; bus_addr = a; bus_wdata = d;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b1, THA, 32'd1);
        tick();
        tick();
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_rvalid", {31'd0, bus_rvalid}, 32'd0);

        // Pass after ten cycles of running.
        for (int i = 0; i < 10; i++) idle_cycle();
        drive(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'd1);
        tick();
        chk("pass_flag", {31'd0, pass}, 32'd1);
        chk("pass_done", {31'd0, done}, 32'd1);
        chk("pass_cycles", cycles, 32'd10);
        chk("pass_failnum", {1'b0, fail_num}, 32'd0);

        // One-cycle reset out of PASS restarts the sequence.
        do_reset();
        chk("rst_pass_done", {31'd0, done}, 32'd0);
        chk("rst_pass_pass", {31'd0, pass}, 32'd0);
        idle_cycle();
        chk("restart_cycles0", cycles, 32'd0);
        idle_cycle();
        chk("restart_cycles1", cycles, 32'd1);

        // Fail with an unaligned hit, then later stores change nothing.
        drive(1'b0, 1'b1, 1'b0, 32'h0000_1002, 32'h0000_0007);
        tick();
        chk("fail_num3", {1'b0, fail_num}, 32'd3);
        chk("fail_pass", {31'd0, pass}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'd1);
        tick();
        chk("fail_sticky_pass", {31'd0, pass}, 32'd0);
        chk("fail_sticky_num", {1'b0, fail_num}, 32'd3);
        chk("fail_frozen_cycles", cycles, 32'd2);

        // Ignored even value, then loads.
        do_reset();
        idle_cycle();
        drive(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'd4);
        tick();
        chk("even_stays_run", {31'd0, done}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'd0);
        tick();
        chk("load_hit", bus_rdata, 32'd4);
        chk("load_hit_valid", {31'd0, bus_rvalid}, 32'd1);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_2000, 32'd0);
        tick();
        chk("load_miss", bus_rdata, 32'd0);
        idle_cycle();
        chk("rvalid_drop", {31'd0, bus_rvalid}, 32'd0);

        // Store and load on the same edge.
        do_reset();
        idle_cycle();
        drive(1'b0, 1'b1, 1'b1, 32'h0000_1000, 32'd5);
        tick();
        chk("rw_old_value", bus_rdata, 32'd0);
        chk("rw_fail_num", {1'b0, fail_num}, 32'd2);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'd0);
        tick();
        chk("rw_tohost_after", bus_rdata, 32'd5);

        // Watchdog.
        do_reset();
        for (int i = 0; i < 21; i++) idle_cycle();
        chk("tmo_flag", {31'd0, timeout}, 32'd1);
        chk("tmo_done", {31'd0, done}, 32'd1);
        chk("tmo_cycles", cycles, 32'd20);
        for (int i = 0; i < 3; i++) idle_cycle();
        chk("tmo_cycles_hold", cycles, 32'd20);

        // Randomized episodes.
        for (int ep = 0; ep < 25; ep++) begin
            do_reset();
            for (int c = 0; c < 40; c++) begin
                logic [31:0] a, d;
                int sel;
                a = ($urandom_range(0, 1) == 1) ? {THA[31:2], 2'($urandom_range(0, 3))}
                                                : (($urandom_range(0, 1) == 1) ? THA + 32'd4
                                                                               : $urandom);
                sel = $urandom_range(0, 9);
                if (sel < 6) d = $urandom & 32'hFFFF_FFFE;
                else if (sel == 6) d = 32'd1;
                else if (sel == 7) d = $urandom | 32'd1;
                else d = $urandom;
                drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 2) == 0), a, d);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
